// File: rtl/out_sram_drain.sv
// Drains the accumulator output SRAM after a matrix job and serialises each
// 32-lane word into a single-element valid/ready stream tagged with (row, col).
module out_sram_drain #(
  parameter int unsigned ACC_BWIDTH             = 32,
  parameter int unsigned PE_ARRAY_NUM_COLS      = 32,
  parameter int unsigned PE_ARRAY_NUM_COLS_LOG2 = 5,
  parameter int unsigned OUT_SRAM_AWIDTH        = 10,
  parameter int unsigned OUT_SRAM_BWIDTH        = 1024,
  parameter int unsigned MAX_M_SIZE_LOG2        = 9,
  parameter int unsigned MAX_N_SIZE_LOG2        = 9
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic [MAX_M_SIZE_LOG2-1:0] M_SIZE_in,
  input  logic [MAX_N_SIZE_LOG2-1:0] N_SIZE_in,
  output logic                       OUT_SRAM_EN_out,
  output logic [OUT_SRAM_AWIDTH-1:0] OUT_SRAM_ADDR_out,
  input  logic [OUT_SRAM_BWIDTH-1:0] OUT_SRAM_RDATA_in,
  output logic                       DOUT_VALID_out,
  input  logic                       DOUT_READY_in,
  output logic [ACC_BWIDTH-1:0]      DOUT_DATA_out,
  output logic [MAX_M_SIZE_LOG2-1:0] DOUT_ROW_out,
  output logic [MAX_N_SIZE_LOG2-1:0] DOUT_COL_out,
  output logic                       DOUT_LAST_out,
  output logic                       BUSY_out,
  output logic                       IS_FINISHED_out
);

  localparam int unsigned MW = MAX_M_SIZE_LOG2;
  localparam int unsigned NW = MAX_N_SIZE_LOG2;
  localparam int unsigned AW = OUT_SRAM_AWIDTH;
  localparam int unsigned LW = PE_ARRAY_NUM_COLS_LOG2;
  localparam int unsigned CW = MAX_N_SIZE_LOG2 + 1;
  localparam int unsigned TW = MAX_N_SIZE_LOG2 - PE_ARRAY_NUM_COLS_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [MW-1:0]          m_q, m_d;
  logic [NW-1:0]          n_q, n_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [MW-1:0]          row_q, row_d;
  logic [TW-1:0]          tile_q, tile_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [OUT_SRAM_BWIDTH-1:0] word_q, word_d;
  logic                   en_q, en_d;
  logic                   valid_q, valid_d;
  logic [ACC_BWIDTH-1:0]  data_q, data_d;
  logic [MW-1:0]          row_out_q, row_out_d;
  logic [NW-1:0]          col_q, col_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   fin_q, fin_d;

  logic [CW-1:0] tile_base;
  logic [CW-1:0] n_ext;
  logic          last_row;
  logic          word_last;
  logic          lane_last;
  logic          next_lane_last;
  logic          first_lane_last;
  logic          handshake;
  logic [LW-1:0] lane_nxt;

  // Position of the current element relative to the job extent
  always_comb begin
    tile_base       = CW'(tile_q) << PE_ARRAY_NUM_COLS_LOG2;
    n_ext           = CW'(n_q);
    last_row        = (row_q == (m_q - MW'(1)));
    word_last       = last_row && ((tile_base + CW'(PE_ARRAY_NUM_COLS)) >= n_ext);
    lane_last       = (lane_q == LW'(PE_ARRAY_NUM_COLS - 1)) ||
                      ((CW'(col_q) + CW'(1)) >= n_ext);
    next_lane_last  = (lane_q == LW'(PE_ARRAY_NUM_COLS - 2)) ||
                      ((CW'(col_q) + CW'(2)) >= n_ext);
    first_lane_last = ((tile_base + CW'(1)) >= n_ext);
    handshake       = valid_q && DOUT_READY_in;
    lane_nxt        = lane_q + LW'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    n_d       = n_q;
    addr_d    = addr_q;
    row_d     = row_q;
    tile_d    = tile_q;
    lane_d    = lane_q;
    word_d    = word_q;
    en_d      = 1'b0;
    valid_d   = valid_q;
    data_d    = data_q;
    row_out_d = row_out_q;
    col_d     = col_q;
    last_d    = last_q;
    fin_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          m_d    = M_SIZE_in;
          n_d    = N_SIZE_in;
          addr_d = '0;
          row_d  = '0;
          tile_d = '0;
          lane_d = '0;
          if ((M_SIZE_in == '0) || (N_SIZE_in == '0)) begin
            state_d = S_DONE;
            fin_d   = 1'b1;
          end else begin
            state_d = S_READ;
            en_d    = 1'b1;
          end
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        word_d    = OUT_SRAM_RDATA_in;
        data_d    = OUT_SRAM_RDATA_in[ACC_BWIDTH-1:0];
        row_out_d = row_q;
        col_d     = NW'(tile_base);
        lane_d    = '0;
        last_d    = word_last && first_lane_last;
        valid_d   = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (handshake) begin
          if (!lane_last) begin
            lane_d = lane_nxt;
            data_d = word_q[int'(lane_nxt)*ACC_BWIDTH +: ACC_BWIDTH];
            col_d  = col_q + NW'(1);
            last_d = word_last && next_lane_last;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (word_last) begin
              state_d = S_DONE;
              fin_d   = 1'b1;
            end else begin
              // Advance to the next word: row-major within a column tile
              state_d = S_READ;
              en_d    = 1'b1;
              addr_d  = addr_q + AW'(1);
              if (last_row) begin
                row_d  = '0;
                tile_d = tile_q + TW'(1);
              end else begin
                row_d = row_q + MW'(1);
              end
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      n_q       <= '0;
      addr_q    <= '0;
      row_q     <= '0;
      tile_q    <= '0;
      lane_q    <= '0;
      en_q      <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      row_out_q <= '0;
      col_q     <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      n_q       <= n_d;
      addr_q    <= addr_d;
      row_q     <= row_d;
      tile_q    <= tile_d;
      lane_q    <= lane_d;
      en_q      <= en_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      row_out_q <= row_out_d;
      col_q     <= col_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      fin_q     <= fin_d;
    end
  end

  // Word buffer carries no control meaning, so it is left out of reset
  always_ff @(posedge CLK) begin
    word_q <= word_d;
  end

  assign OUT_SRAM_EN_out   = en_q;
  assign OUT_SRAM_ADDR_out = addr_q;
  assign DOUT_VALID_out    = valid_q;
  assign DOUT_DATA_out     = data_q;
  assign DOUT_ROW_out      = row_out_q;
  assign DOUT_COL_out      = col_q;
  assign DOUT_LAST_out     = last_q;
  assign BUSY_out          = busy_q;
  assign IS_FINISHED_out   = fin_q;

endmodule
